fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS32 pipeline: owns the PC, issues requests to instruction memory, and loads the IF/ID pipeline register consumed by ID-stage decode (control_main, Hazard_Unit). It honours the Hazard_Unit stall outputs (PCWrite, IFID_Write) and the resolved-branch redirect from MEM. A one-entry holding buffer absorbs an instruction that returns while IF/ID is stalled, so variable-latency instruction memory is supported.

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_skid.sv | 39 +++
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 tb/tb_fetch_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared state encodings and constants for the MIPS32 fetch stage
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HELD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

    // sll $0,$0,0: decodes as an R-format write to $0, so it is a safe bubble
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry holding buffer for an instruction returned while IF/ID is stalled
module fetch_skid (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        unload_i,
    input  logic        clear_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        full_o
);

    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        full_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q <= 32'h0;
            pc_q    <= 32'h0;
            full_q  <= 1'b0;
        end else if (clear_i) begin
            full_q  <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            full_q  <= 1'b1;
        end else if (unload_i) begin
            full_q  <= 1'b0;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign full_o  = full_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, imem requests, IF/ID register; IF_PERF_CNT_EN adds fetch/bubble counters
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IFID_Write,
    input  logic        PCSrc,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_PCplus4,
    output logic        IF_ID_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  req_pc_q;
    logic [31:0]  ifid_instr_q;
    logic [31:0]  ifid_pc4_q;
    logic         ifid_valid_q;

    logic         issue;
    logic         ifid_load;
    logic [31:0]  ifid_instr_d;
    logic [31:0]  ifid_pc4_d;
    logic         ifid_valid_d;
    logic         skid_load;
    logic         skid_unload;
    logic [31:0]  skid_instr;
    logic [31:0]  skid_pc;
    logic         skid_full;

    always_comb begin
        issue = 1'b0;
        if (PCWrite && !PCSrc) begin
            case (state_q)
                S_IDLE:  issue = 1'b1;
                S_WAIT:  issue = imem_valid && IFID_Write;
                S_HELD:  issue = IFID_Write;
                default: issue = 1'b0;
            endcase
        end
    end

    assign imem_req  = issue;
    assign imem_addr = {pc_q[31:2], 2'b00};

    // A redirect forces a bubble into IF/ID even when decode is stalled
    always_comb begin
        ifid_load    = PCSrc || IFID_Write;
        ifid_instr_d = NOP_INSTR;
        ifid_pc4_d   = 32'h0;
        ifid_valid_d = 1'b0;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        if (!PCSrc) begin
            if (IFID_Write) begin
                if (state_q == S_WAIT && imem_valid) begin
                    ifid_instr_d = imem_rdata;
                    ifid_pc4_d   = pc_plus4(req_pc_q);
                    ifid_valid_d = 1'b1;
                end else if (state_q == S_HELD && skid_full) begin
                    ifid_instr_d = skid_instr;
                    ifid_pc4_d   = pc_plus4(skid_pc);
                    ifid_valid_d = 1'b1;
                    skid_unload  = 1'b1;
                end
            end else if (state_q == S_WAIT && imem_valid) begin
                skid_load = 1'b1;
            end
        end
    end

    fetch_skid u_skid (
        .clk_i    (clock),
        .rst_ni   (reset),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (PCSrc),
        .instr_i  (imem_rdata),
        .pc_i     (req_pc_q),
        .instr_o  (skid_instr),
        .pc_o     (skid_pc),
        .full_o   (skid_full)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
        end else begin
            if (ifid_load) begin
                ifid_instr_q <= ifid_instr_d;
                ifid_pc4_q   <= ifid_pc4_d;
                ifid_valid_q <= ifid_valid_d;
            end
            if (PCSrc) begin
                pc_q <= branch_target;
                // Only a request still in flight after this edge needs draining
                if ((state_q == S_WAIT || state_q == S_DROP) && !imem_valid)
                    state_q <= S_DROP;
                else
                    state_q <= S_IDLE;
            end else begin
                if (issue) begin
                    req_pc_q <= pc_q;
                    pc_q     <= pc_plus4(pc_q);
                end
                case (state_q)
                    S_IDLE: if (issue) state_q <= S_WAIT;
                    S_WAIT: begin
                        if (imem_valid) begin
                            if (!IFID_Write) state_q <= S_HELD;
                            else             state_q <= issue ? S_WAIT : S_IDLE;
                        end
                    end
                    S_HELD: if (IFID_Write) state_q <= issue ? S_WAIT : S_IDLE;
                    S_DROP: if (imem_valid) state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign IF_ID_instr   = ifid_instr_q;
    assign IF_ID_PCplus4 = ifid_pc4_q;
    assign IF_ID_valid   = ifid_valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubbles_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= 32'h0;
            perf_bubbles_q <= 32'h0;
        end else if (ifid_load) begin
            if (ifid_valid_d) perf_fetched_q <= perf_fetched_q + 32'd1;
            else              perf_bubbles_q <= perf_bubbles_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with a variable-latency memory model
module tb_fetch_stage;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        PCWrite = 1'b1;
    logic        IFID_Write = 1'b1;
    logic        PCSrc = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_PCplus4;
    logic        IF_ID_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    fetch_stage dut (
        .clock         (clock),
        .reset         (reset),
        .PCWrite       (PCWrite),
        .IFID_Write    (IFID_Write),
        .PCSrc         (PCSrc),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .IF_ID_instr   (IF_ID_instr),
        .IF_ID_PCplus4 (IF_ID_PCplus4),
        .IF_ID_valid   (IF_ID_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_bubbles  (perf_bubbles)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        pw, iw, ps;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] instr, pc4;
    } vec_t;

    vec_t        tbl[17];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat = 1;
    bit          pend = 0;
    logic [31:0] p_addr = 32'h0;
    int          p_cnt = 0;
    logic        cur_req;
    logic [31:0] cur_addr;
    bit          sb_on = 0;
    logic [31:0] exp_q[$];
    int          valid_loads = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tv(input int i, input logic pw, input logic iw, input logic ps, input logic [31:0] tgt,
                      input logic req, input logic [31:0] addr, input logic vld,
                      input logic [31:0] instr, input logic [31:0] pc4);
        tbl[i].pw = pw; tbl[i].iw = iw; tbl[i].ps = ps; tbl[i].tgt = tgt;
        tbl[i].req = req; tbl[i].addr = addr; tbl[i].vld = vld;
        tbl[i].instr = instr; tbl[i].pc4 = pc4;
    endtask

    // One clock: drive at negedge, sample request, take the edge, update memory model and scoreboard
    task automatic step(input logic pw, input logic iw, input logic ps, input logic [31:0] tgt);
        logic        pres;
        logic [31:0] e;
        PCWrite = pw; IFID_Write = iw; PCSrc = ps; branch_target = tgt;
        pres = pend && (p_cnt == 1);
        imem_valid = pres;
        imem_rdata = pres ? p_addr : 32'hdead_beef;
        #1;
        cur_req  = imem_req;
        cur_addr = imem_addr;
        if (cur_req) chk("one_outstanding", {31'd0, pend && !pres}, 32'd0);
        @(posedge clock);
        #1;
        if (pres) pend = 0;
        else if (pend) p_cnt--;
        if (cur_req) begin
            pend = 1; p_addr = cur_addr; p_cnt = lat;
        end
        if (iw || ps) begin
            if (IF_ID_valid) begin
                valid_loads++;
                if (sb_on) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL sb_unexpected: got %h expected none", IF_ID_instr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_instr", IF_ID_instr, e);
                        chk("sb_pc4", IF_ID_PCplus4, e + 32'd4);
                    end
                end
            end else if (sb_on) begin
                chk("bubble_instr", IF_ID_instr, 32'h0);
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        PCWrite = 1'b1; IFID_Write = 1'b1; PCSrc = 1'b0; imem_valid = 1'b0;
        pend = 0;
        exp_q.delete();
        valid_loads = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        tv( 0, T, T, F, 32'h0,   T, 32'h0,   F, 32'h0,   32'h0);
        tv( 1, T, T, F, 32'h0,   T, 32'h4,   T, 32'h0,   32'h4);
        tv( 2, T, T, F, 32'h0,   T, 32'h8,   T, 32'h4,   32'h8);
        tv( 3, T, F, F, 32'h0,   F, 32'h0,   T, 32'h4,   32'h8);
        tv( 4, T, F, F, 32'h0,   F, 32'h0,   T, 32'h4,   32'h8);
        tv( 5, T, T, F, 32'h0,   T, 32'hc,   T, 32'h8,   32'hc);
        tv( 6, T, T, F, 32'h0,   T, 32'h10,  T, 32'hc,   32'h10);
        tv( 7, F, T, F, 32'h0,   F, 32'h0,   T, 32'h10,  32'h14);
        tv( 8, F, T, F, 32'h0,   F, 32'h0,   F, 32'h0,   32'h0);
        tv( 9, T, T, F, 32'h0,   T, 32'h14,  F, 32'h0,   32'h0);
        tv(10, T, T, T, 32'h100, F, 32'h0,   F, 32'h0,   32'h0);
        tv(11, T, T, F, 32'h0,   T, 32'h100, F, 32'h0,   32'h0);
        tv(12, T, T, F, 32'h0,   T, 32'h104, T, 32'h100, 32'h104);
        tv(13, T, F, F, 32'h0,   F, 32'h0,   T, 32'h100, 32'h104);
        tv(14, T, F, T, 32'h200, F, 32'h0,   F, 32'h0,   32'h0);
        tv(15, T, T, F, 32'h0,   T, 32'h200, F, 32'h0,   32'h0);
        tv(16, T, T, F, 32'h0,   T, 32'h204, T, 32'h200, 32'h204);

        #1 reset = 1'b0;
        #1;
        chk("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("rst_instr", IF_ID_instr, 32'h0);
        chk("rst_pc4", IF_ID_PCplus4, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);

        // Zero-wait memory: streaming, stall into buffer, redirects
        lat = 1;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].pw, tbl[i].iw, tbl[i].ps, tbl[i].tgt);
            chk($sformatf("v%0d_req", i), {31'd0, cur_req}, {31'd0, tbl[i].req});
            if (tbl[i].req) chk($sformatf("v%0d_addr", i), cur_addr, tbl[i].addr);
            chk($sformatf("v%0d_valid", i), {31'd0, IF_ID_valid}, {31'd0, tbl[i].vld});
            chk($sformatf("v%0d_instr", i), IF_ID_instr, tbl[i].instr);
            if (tbl[i].vld) chk($sformatf("v%0d_pc4", i), IF_ID_PCplus4, tbl[i].pc4);
        end

        // Three-cycle memory: valid on every third load, bubbles between
        lat = 3;
        do_reset();
        sb_on = 1;
        for (int a = 0; a < 9; a++) exp_q.push_back(32'(a * 4));
        for (int c = 0; c < 30; c++) step(T, T, F, 32'h0);
        chk("lat3_valid_loads", 32'(valid_loads), 32'd9);
        chk("lat3_sb_drained", 32'(exp_q.size()), 32'd0);

        // Redirect while waiting: late response must be dropped
        do_reset();
        sb_on = 1;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        step(T, T, F, 32'h0);
        chk("drop_c0_req", {31'd0, cur_req}, 32'd1);
        chk("drop_c0_addr", cur_addr, 32'h0);
        step(T, T, T, 32'h100);
        chk("drop_c1_req", {31'd0, cur_req}, 32'd0);
        chk("drop_c1_valid", {31'd0, IF_ID_valid}, 32'd0);
        for (int c = 2; c < 4; c++) begin
            step(T, T, F, 32'h0);
            chk($sformatf("drop_c%0d_req", c), {31'd0, cur_req}, 32'd0);
        end
        step(T, T, F, 32'h0);
        chk("drop_c4_req", {31'd0, cur_req}, 32'd1);
        chk("drop_c4_addr", cur_addr, 32'h100);
        for (int c = 5; c < 11; c++) step(T, T, F, 32'h0);
        chk("drop_sb_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with a request outstanding
        do_reset();
        sb_on = 0;
        for (int c = 0; c < 7; c++) step(T, T, F, 32'h0);
        chk("pre_rst_pc4", IF_ID_PCplus4, 32'h8);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("mid_rst_instr", IF_ID_instr, 32'h0);
        chk("mid_rst_pc4", IF_ID_PCplus4, 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        pend = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        step(T, T, F, 32'h0);
        chk("restart_req", {31'd0, cur_req}, 32'd1);
        chk("restart_addr", cur_addr, 32'h0);
        for (int c = 1; c < 4; c++) step(T, T, F, 32'h0);
        chk("restart_valid", {31'd0, IF_ID_valid}, 32'd1);
        chk("restart_pc4", IF_ID_PCplus4, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
